// File: rtl/tag_sched_pkg.sv
// Shared types and helpers for the tag array scheduler.
//   tag_sched_state_e : CLEAR sweeps zeros into the array, RUN serves requests
//   addr_width()      : index width for a given entry count
package tag_sched_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } tag_sched_state_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/tag_read_arbiter.sv
// Two-way read-port arbiter: snoop has fixed priority over core, but after
// STARVE_LIMIT consecutive snoop wins against a waiting core, the core wins once.
// Ports:
//   clock, reset        clock, async active-low reset
//   arb_en              arbitration allowed this cycle (RUN, no flush)
//   core_valid          core lookup pending
//   snp_valid           snoop lookup pending
//   grant[1:0]          one-hot grant: [0]=core, [1]=snoop
module tag_read_arbiter
  import tag_sched_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arb_en,
  input  logic       core_valid,
  input  logic       snp_valid,
  output logic [1:0] grant
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = core_valid && (starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    grant = '0;
    if (arb_en) begin
      if (snp_valid && !starved) begin
        grant = 2'b10;
      end else if (core_valid) begin
        grant = 2'b01;
      end
    end
  end

  // Counts snoop wins only while the core is actually waiting; a core grant or
  // an idle core restarts the count. Holds when no grant happens (CLEAR/flush).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!core_valid || grant[0]) begin
      starve_cnt <= '0;
    end else if (grant[1] && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tag_array_scheduler.sv
// Sequences and shares one tag_array port A: clears every entry after reset
// and on flush, arbitrates the read port between core and snoop lookups, and
// passes fill writes straight through to the write port.
// Ports:
//   clock, reset                        clock, async active-low reset
//   flush_req                           pulse: re-clear whole array
//   init_done / flush_done              in RUN / last clear write this cycle
//   core_req_* / core_resp_*            core lookup request / result (1 cycle later)
//   snp_req_*  / snp_resp_*             snoop lookup request / result (1 cycle later)
//   fill_valid/ready/addr/data          tag write request
//   ta_read_* / ta_write_*              tag_array port A (read data combinational)
module tag_array_scheduler
  import tag_sched_pkg::*;
#(
  parameter int unsigned ID           = 0,
  parameter int unsigned TAG_WIDTH    = 28,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned AW          = addr_width(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush_req,
  output logic                 init_done,
  output logic                 flush_done,
  input  logic                 core_req_valid,
  output logic                 core_req_ready,
  input  logic [AW-1:0]        core_req_addr,
  output logic                 core_resp_valid,
  output logic [TAG_WIDTH-1:0] core_resp_tag,
  input  logic                 snp_req_valid,
  output logic                 snp_req_ready,
  input  logic [AW-1:0]        snp_req_addr,
  output logic                 snp_resp_valid,
  output logic [TAG_WIDTH-1:0] snp_resp_tag,
  input  logic                 fill_valid,
  output logic                 fill_ready,
  input  logic [AW-1:0]        fill_addr,
  input  logic [TAG_WIDTH-1:0] fill_data,
  output logic                 ta_read_en,
  output logic [AW-1:0]        ta_read_addr,
  input  logic [TAG_WIDTH-1:0] ta_read_data,
  output logic                 ta_write_en,
  output logic [AW-1:0]        ta_write_addr,
  output logic [TAG_WIDTH-1:0] ta_write_data
);

  // ID only tags debug output; no logic depends on it.
  logic unused_id;
  assign unused_id = ^ID;

  tag_sched_state_e     state, state_nxt;
  logic [AW-1:0]        sweep_cnt, sweep_nxt;
  logic                 arb_en;
  logic [1:0]           grant;
  logic [TAG_WIDTH-1:0] rd_data;

  // Outputs are gated by reset so they drop the instant reset asserts.
  assign arb_en = reset && (state == RUN) && !flush_req;

  tag_read_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clock      (clock),
    .reset      (reset),
    .arb_en     (arb_en),
    .core_valid (core_req_valid),
    .snp_valid  (snp_req_valid),
    .grant      (grant)
  );

  assign core_req_ready = grant[0];
  assign snp_req_ready  = grant[1];
  assign ta_read_en     = |grant;

  always_comb begin
    state_nxt     = state;
    sweep_nxt     = sweep_cnt;
    init_done     = 1'b0;
    flush_done    = 1'b0;
    fill_ready    = 1'b0;
    ta_read_addr  = '0;
    ta_write_en   = 1'b0;
    ta_write_addr = '0;
    ta_write_data = '0;
    if (reset) begin
      unique case (state)
        CLEAR: begin
          ta_write_en   = 1'b1;
          ta_write_addr = sweep_cnt;
          sweep_nxt     = sweep_cnt + 1'b1;
          if (sweep_cnt == AW'(DEPTH - 1)) begin
            flush_done = 1'b1;
            state_nxt  = RUN;
            sweep_nxt  = '0;
          end
        end
        RUN: begin
          init_done = 1'b1;
          if (flush_req) begin
            state_nxt = CLEAR;
            sweep_nxt = '0;
          end else begin
            fill_ready = 1'b1;
            if (fill_valid) begin
              ta_write_en   = 1'b1;
              ta_write_addr = fill_addr;
              ta_write_data = fill_data;
            end
            if (grant[1]) begin
              ta_read_addr = snp_req_addr;
            end else if (grant[0]) begin
              ta_read_addr = core_req_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A same-cycle fill to the read index wins over the stale array contents.
  assign rd_data = (ta_write_en && (ta_write_addr == ta_read_addr)) ? ta_write_data
                                                                    : ta_read_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      core_resp_valid <= 1'b0;
      core_resp_tag   <= '0;
      snp_resp_valid  <= 1'b0;
      snp_resp_tag    <= '0;
    end else begin
      core_resp_valid <= grant[0];
      snp_resp_valid  <= grant[1];
      if (grant[0]) core_resp_tag <= rd_data;
      if (grant[1]) snp_resp_tag  <= rd_data;
    end
  end

endmodule

// File: tb/tb_tag_array_scheduler.sv
module tb_tag_array_scheduler;
  localparam int TW = 28;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int LIM = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush_req = 1'b0;
  logic init_done, flush_done;
  logic core_req_valid = 1'b0, core_req_ready;
  logic [AW-1:0] core_req_addr = '0;
  logic core_resp_valid;
  logic [TW-1:0] core_resp_tag;
  logic snp_req_valid = 1'b0, snp_req_ready;
  logic [AW-1:0] snp_req_addr = '0;
  logic snp_resp_valid;
  logic [TW-1:0] snp_resp_tag;
  logic fill_valid = 1'b0, fill_ready;
  logic [AW-1:0] fill_addr = '0;
  logic [TW-1:0] fill_data = '0;
  logic ta_read_en, ta_write_en;
  logic [AW-1:0] ta_read_addr, ta_write_addr;
  logic [TW-1:0] ta_read_data, ta_write_data;

  always #5 clock = ~clock;

  tag_array_scheduler #(
    .ID(0), .TAG_WIDTH(TW), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)
  ) dut (
    .clock(clock), .reset(reset), .flush_req(flush_req),
    .init_done(init_done), .flush_done(flush_done),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_addr(core_req_addr), .core_resp_valid(core_resp_valid),
    .core_resp_tag(core_resp_tag),
    .snp_req_valid(snp_req_valid), .snp_req_ready(snp_req_ready),
    .snp_req_addr(snp_req_addr), .snp_resp_valid(snp_resp_valid),
    .snp_resp_tag(snp_resp_tag),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .ta_read_en(ta_read_en), .ta_read_addr(ta_read_addr), .ta_read_data(ta_read_data),
    .ta_write_en(ta_write_en), .ta_write_addr(ta_write_addr), .ta_write_data(ta_write_data)
  );

  // Tag array stand-in (no reset). The scribble port fills it with junk during reset.
  logic [TW-1:0] ta_mem [DEPTH];
  logic scrib_en = 1'b0;
  logic [AW-1:0] scrib_addr = '0;
  logic [TW-1:0] scrib_val = '0;
  always @(posedge clock) begin
    if (ta_write_en) ta_mem[ta_write_addr] <= ta_write_data;
    else if (scrib_en) ta_mem[scrib_addr] <= scrib_val;
  end
  assign ta_read_data = ta_mem[ta_read_addr];

  // Reference model state
  bit m_run;
  int m_sweep, m_starve;
  logic [TW-1:0] m_mem [DEPTH];
  bit m_cv, m_sv;
  logic [TW-1:0] m_ct, m_st;

  int total = 0;
  int bad = 0;
  string seq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_sweep = 0; m_starve = 0;
    m_cv = 1'b0; m_sv = 1'b0; m_ct = '0; m_st = '0;
  endtask

  task automatic rst_check();
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_flush_done", 32'(flush_done), 0);
    chk("rst_core_ready", 32'(core_req_ready), 0);
    chk("rst_snp_ready", 32'(snp_req_ready), 0);
    chk("rst_fill_ready", 32'(fill_ready), 0);
    chk("rst_read_en", 32'(ta_read_en), 0);
    chk("rst_write_en", 32'(ta_write_en), 0);
    chk("rst_core_resp_valid", 32'(core_resp_valid), 0);
    chk("rst_snp_resp_valid", 32'(snp_resp_valid), 0);
    chk("rst_core_resp_tag", 32'(core_resp_tag), 0);
    chk("rst_snp_resp_tag", 32'(snp_resp_tag), 0);
  endtask

  function automatic logic [TW-1:0] lookup(input logic [AW-1:0] a, input bit wr);
    if (wr && fill_addr == a) return fill_data;
    return m_mem[a];
  endfunction

  // Inputs are set at a negedge; check at +1, advance model, move to next negedge.
  task automatic step();
    bit cw = 1'b0, sw = 1'b0, fr = 1'b0, wr = 1'b0;
    #1;
    if (!m_run) begin
      chk("init_done", 32'(init_done), 0);
      chk("flush_done", 32'(flush_done), 32'(m_sweep == DEPTH - 1));
      chk("core_ready", 32'(core_req_ready), 0);
      chk("snp_ready", 32'(snp_req_ready), 0);
      chk("fill_ready", 32'(fill_ready), 0);
      chk("read_en", 32'(ta_read_en), 0);
      chk("read_addr", 32'(ta_read_addr), 0);
      chk("clr_write_en", 32'(ta_write_en), 1);
      chk("clr_write_addr", 32'(ta_write_addr), 32'(m_sweep));
      chk("clr_write_data", 32'(ta_write_data), 0);
    end else begin
      fr = !flush_req;
      cw = fr && core_req_valid && (!snp_req_valid || m_starve == LIM);
      sw = fr && snp_req_valid && !cw;
      wr = fr && fill_valid;
      chk("init_done", 32'(init_done), 1);
      chk("flush_done", 32'(flush_done), 0);
      chk("core_ready", 32'(core_req_ready), 32'(cw));
      chk("snp_ready", 32'(snp_req_ready), 32'(sw));
      chk("fill_ready", 32'(fill_ready), 32'(fr));
      chk("read_en", 32'(ta_read_en), 32'(cw | sw));
      chk("read_addr", 32'(ta_read_addr), sw ? 32'(snp_req_addr) : cw ? 32'(core_req_addr) : 0);
      chk("write_en", 32'(ta_write_en), 32'(wr));
      if (wr) begin
        chk("write_addr", 32'(ta_write_addr), 32'(fill_addr));
        chk("write_data", 32'(ta_write_data), 32'(fill_data));
      end
    end
    chk("core_resp_valid", 32'(core_resp_valid), 32'(m_cv));
    if (m_cv) chk("core_resp_tag", 32'(core_resp_tag), 32'(m_ct));
    chk("snp_resp_valid", 32'(snp_resp_valid), 32'(m_sv));
    if (m_sv) chk("snp_resp_tag", 32'(snp_resp_tag), 32'(m_st));
    // advance model
    m_cv = cw; m_sv = sw;
    if (cw) m_ct = lookup(core_req_addr, wr);
    if (sw) m_st = lookup(snp_req_addr, wr);
    if (!core_req_valid || cw) m_starve = 0;
    else if (sw && m_starve < LIM) m_starve++;
    if (!m_run) begin
      m_mem[m_sweep] = '0;
      if (m_sweep == DEPTH - 1) begin m_run = 1'b1; m_sweep = 0; end
      else m_sweep++;
    end else if (flush_req) begin
      m_run = 1'b0; m_sweep = 0;
    end else if (wr) begin
      m_mem[fill_addr] = fill_data;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    core_req_valid = 1'b0; snp_req_valid = 1'b0; fill_valid = 1'b0; flush_req = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset held: scribble junk into the array, outputs stay quiet.
    for (int i = 0; i < DEPTH; i++) begin
      scrib_en = 1'b1; scrib_addr = AW'(i); scrib_val = TW'($urandom);
      @(negedge clock);
    end
    scrib_en = 1'b0;
    #1 rst_check();
    reset = 1'b1;

    // Power-up sweep; requests and flush are ignored while clearing.
    for (int i = 0; i < DEPTH; i++) begin
      core_req_valid = (i % 3 == 0); snp_req_valid = (i % 4 == 1);
      flush_req = (i == 5); fill_valid = (i == 7);
      step();
    end
    idle();

    // Fill then core lookup.
    fill_valid = 1'b1; fill_addr = 4'd3; fill_data = 28'hABC; step();
    idle(); core_req_valid = 1'b1; core_req_addr = 4'd3; step();
    idle();
    #1 chk("core_lookup_abc", 32'(core_resp_tag), 32'h0ABC);
    chk("core_lookup_valid", 32'(core_resp_valid), 1);
    step();

    // Continuous contention: snoop wins LIM times, then core.
    seq = "";
    core_req_valid = 1'b1; snp_req_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      core_req_addr = AW'($urandom); snp_req_addr = AW'($urandom);
      #1 seq = {seq, snp_req_ready ? "S" : core_req_ready ? "C" : "-"};
      step();
    end
    idle();
    total++;
    assert (seq == "SSSSCSSSSCSSSSC") else begin
      bad++;
      $error("FAIL grant_pattern observed=%s expected=SSSSCSSSSCSSSSC", seq);
    end

    // Same-cycle fill and snoop read to index 5: forwarded data.
    fill_valid = 1'b1; fill_addr = 4'd5; fill_data = 28'h123;
    snp_req_valid = 1'b1; snp_req_addr = 4'd5; step();
    idle();
    #1 chk("snoop_forward", 32'(snp_resp_tag), 32'h123);
    step();

    // Flush with a core response in flight.
    core_req_valid = 1'b1; core_req_addr = 4'd3; step();
    idle(); flush_req = 1'b1;
    #1 chk("flush_inflight_valid", 32'(core_resp_valid), 1);
    chk("flush_inflight_tag", 32'(core_resp_tag), 32'h0ABC);
    step();
    flush_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      core_req_valid = 1'b1; snp_req_valid = (i % 2 == 0); step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      core_req_valid = 1'b1; core_req_addr = (i == 0) ? 4'd3 : AW'($urandom); step();
      idle();
      #1 chk("post_flush_zero", 32'(core_resp_tag), 0);
    end
    step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      core_req_valid = 1'($urandom); core_req_addr = AW'($urandom);
      snp_req_valid = 1'($urandom); snp_req_addr = AW'($urandom);
      fill_valid = 1'($urandom); fill_addr = AW'($urandom); fill_data = TW'($urandom);
      flush_req = ($urandom_range(0, 63) == 0);
      step();
    end
    idle();
    for (int i = 0; i < 20 && !m_run; i++) step();
    chk("reach_run", 32'(m_run), 1);

    // Reset with a response pending: it is dropped.
    core_req_valid = 1'b1; core_req_addr = 4'd3; step();
    idle();
    #2 reset = 1'b0;
    #1 rst_check();
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) step();

    // Reset mid-sweep at sweep_cnt 7, then a full restart from addr 0.
    #2 chk("sweep7_write_en", 32'(ta_write_en), 1);
    chk("sweep7_addr", 32'(ta_write_addr), 7);
    reset = 1'b0;
    #1 rst_check();
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
